mem_unit: RTL and testbench

Unified instruction/data memory stage for the multi-cycle MIPS datapath, sitting directly below the control FSM. It holds the word-addressed memory array, the instruction register (IR) and the memory data register (MDR). It performs the fetch, load and store accesses requested by the control signals, and returns `op_code`/`func` to the control FSM. It also flags illegal accesses and counts completed fetches.

---
 rtl/mem_unit.sv | 112 +++++++++++
 tb/tb_mem_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_unit.sv
// Unified instruction/data memory stage for the multi-cycle MIPS datapath:
// word array plus IR and MDR, a sticky illegal-access flag and a fetch counter.
module mem_unit #(
    parameter int    ADDR_WIDTH = 10,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_data,
    input  logic [31:0] pc,
    input  logic [31:0] z_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        ir_write,
    input  logic [31:0] wr_data,
    output logic [31:0] ir,
    output logic [5:0]  op_code,
    output logic [5:0]  func,
    output logic [31:0] mdr,
    output logic        access_err,
    output logic [31:0] fetch_count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem_r [DEPTH];
    logic [31:0]           ir_r;
    logic [31:0]           mdr_r;
    logic [31:0]           fetch_count_r;
    logic                  access_err_r;

    logic [31:0]           addr_s;
    logic [ADDR_WIDTH-1:0] index_s;
    logic [31:0]           rd_word_s;
    logic                  any_req_s;
    logic                  legal_s;
    logic                  do_fetch_s;
    logic                  do_load_s;
    logic                  do_store_s;
    logic                  err_s;

    // Stores may only target data space; instruction space is read-only.
    function automatic logic access_legal(
        input logic [31:0] addr,
        input logic        rd,
        input logic        wr,
        input logic        is_data
    );
        logic aligned;
        logic in_range;
        aligned  = (addr[1:0] == 2'b00);
        in_range = ((addr >> (ADDR_WIDTH + 2)) == 32'd0);
        return aligned && in_range && !(rd && wr) && !(wr && !is_data);
    endfunction

    // Address select, combinational array read and access decode.
    always_comb begin
        addr_s     = inst_data ? z_addr : pc;
        index_s    = addr_s[ADDR_WIDTH+1:2];
        rd_word_s  = mem_r[index_s];
        any_req_s  = mem_read | mem_write;
        legal_s    = access_legal(addr_s, mem_read, mem_write, inst_data);
        do_fetch_s = 1'b0;
        do_load_s  = 1'b0;
        do_store_s = 1'b0;
        err_s      = 1'b0;
        if (any_req_s && legal_s) begin
            do_fetch_s = mem_read & ir_write & ~inst_data;
            do_load_s  = mem_read & inst_data;
            do_store_s = mem_write & inst_data;
        end else if (any_req_s) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Array write; the reset gate keeps a store from landing while reset is held.
    always_ff @(posedge clk) begin
        if (do_store_s && !reset) begin
            mem_r[index_s] <= wr_data;
        end
    end

    // IR, MDR, fetch counter and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_r          <= 32'd0;
            mdr_r         <= 32'd0;
            fetch_count_r <= 32'd0;
            access_err_r  <= 1'b0;
        end else begin
            if (do_fetch_s) begin
                ir_r          <= rd_word_s;
                fetch_count_r <= fetch_count_r + 32'd1;
            end
            if (do_load_s) begin
                mdr_r <= rd_word_s;
            end
            if (err_s) begin
                access_err_r <= 1'b1;
            end
        end
    end

    assign ir          = ir_r;
    assign op_code     = ir_r[31:26];
    assign func        = ir_r[5:0];
    assign mdr         = mdr_r;
    assign access_err  = access_err_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: directed scenarios followed by randomized traffic,
// compared against a word-level reference model of the memory stage.
module tb_mem_unit;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        inst_data = 1'b0;
    logic [31:0] pc        = 32'd0;
    logic [31:0] z_addr    = 32'd0;
    logic        mem_read  = 1'b0;
    logic        mem_write = 1'b0;
    logic        ir_write  = 1'b0;
    logic [31:0] wr_data   = 32'd0;
    logic [31:0] ir;
    logic [5:0]  op_code;
    logic [5:0]  func;
    logic [31:0] mdr;
    logic        access_err;
    logic [31:0] fetch_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_mem [int];
    logic [31:0] m_ir  = 32'd0;
    logic [31:0] m_mdr = 32'd0;
    logic [31:0] m_fc  = 32'd0;
    logic        m_err = 1'b0;

    always #5 clk = ~clk;

    mem_unit #(.ADDR_WIDTH(AW), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset), .inst_data(inst_data), .pc(pc), .z_addr(z_addr),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .wr_data(wr_data),
        .ir(ir), .op_code(op_code), .func(func), .mdr(mdr),
        .access_err(access_err), .fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ir"},      ir, m_ir);
        chk({tag, ".op_code"}, {26'd0, op_code}, {26'd0, m_ir[31:26]});
        chk({tag, ".func"},    {26'd0, func}, {26'd0, m_ir[5:0]});
        chk({tag, ".mdr"},     mdr, m_mdr);
        chk({tag, ".err"},     {31'd0, access_err}, {31'd0, m_err});
        chk({tag, ".fcount"},  fetch_count, m_fc);
    endtask

    // Reference: one access per cycle, judged on the byte address it names.
    task automatic model_edge();
        longint unsigned a;
        bit ok;
        int w;
        a  = inst_data ? z_addr : pc;
        ok = (a % 4 == 0) && (a < 4 * DEPTH) && !(mem_read && mem_write)
             && !(mem_write && !inst_data);
        w  = int'(a / 4);
        if (mem_read || mem_write) begin
            if (!ok) m_err = 1'b1;
            else if (mem_write) m_mem[w] = wr_data;
            else if (inst_data) m_mdr = m_mem[w];
            else if (ir_write) begin
                m_ir = m_mem[w];
                m_fc = m_fc + 32'd1;
            end
        end
    endtask

    task automatic drive(input logic id, input logic rd, input logic wr, input logic iw,
                         input logic [31:0] p, input logic [31:0] z, input logic [31:0] d);
        inst_data = id; mem_read = rd; mem_write = wr; ir_write = iw;
        pc = p; z_addr = z; wr_data = d;
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_clear();
        m_ir = 32'd0; m_mdr = 32'd0; m_fc = 32'd0; m_err = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        reset = 1'b1;
        model_clear();
        #1;
        check_all(tag);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int kind;
        int sel;
        logic [31:0] a;

        #1;
        check_all("por");
        @(negedge clk);
        reset = 1'b0;

        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0, 32'h8C220004); cycle("pre0");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'h4, 32'h00000020); cycle("pre1");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'd0, 32'd0);        cycle("warm_f");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h4, 32'd0);        cycle("warm_l");

        do_reset("rst_mid");
        chk("rst_ir_zero", ir, 32'd0);
        chk("rst_mdr_zero", mdr, 32'd0);

        // A store in flight while reset is held must not land.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0, 32'hBAD0BAD0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_abort");
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0, 32'd0); cycle("rst_abort_ld");
        chk("rst_abort_mdr", mdr, 32'h8C220004);
        do_reset("rst2");

        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'd0, 32'd0); cycle("fetch0");
        chk("fetch0_ir", ir, 32'h8C220004);
        chk("fetch0_op", {26'd0, op_code}, 32'h23);
        chk("fetch0_cnt", fetch_count, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 32'd0, 32'd0); cycle("fetch4");
        chk("fetch4_func", {26'd0, func}, 32'h20);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 32'd0); cycle("load0");
        chk("load0_mdr", mdr, 32'h8C220004);
        chk("load0_ir_kept", ir, 32'h00000020);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'h10, 32'hDEADBEEF); cycle("st10");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h10, 32'd0);        cycle("ld10");
        chk("ld10_mdr", mdr, 32'hDEADBEEF);
        chk("ld10_err", {31'd0, access_err}, 32'd0);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'h20, 32'h11111111); cycle("st20a");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'h20, 32'h22222222); cycle("rdwr20");
        chk("rdwr_err", {31'd0, access_err}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h20, 32'd0);        cycle("rdwr_chk");
        chk("rdwr_mem", mdr, 32'h11111111);
        do_reset("rst3");

        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'h20, 32'h11111111); cycle("st20b");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h20, 32'd0);        cycle("ld20b");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1000, 32'd0);      cycle("oor");
        chk("oor_err", {31'd0, access_err}, 32'd1);
        chk("oor_mdr", mdr, 32'h11111111);
        do_reset("rst4");

        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'h20, 32'h11111111); cycle("st20c");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 32'h33333333); cycle("wr_inst");
        chk("wr_inst_err", {31'd0, access_err}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h20, 32'd0);        cycle("wr_inst_chk");
        chk("wr_inst_mem", mdr, 32'h11111111);
        do_reset("rst5");

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h10, 32'd0); cycle("mis_pre");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h12, 32'd0); cycle("mis");
        chk("mis_mdr", mdr, 32'hDEADBEEF);
        chk("mis_err", {31'd0, access_err}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h20, 32'd0); cycle("mis_sticky");
        chk("mis_sticky_err", {31'd0, access_err}, 32'd1);
        do_reset("rst6");
        chk("rst6_err", {31'd0, access_err}, 32'd0);

        force dut.fetch_count_r = 32'hFFFFFFFE;
        #1;
        release dut.fetch_count_r;
        m_fc = 32'hFFFFFFFE;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'd0, 32'd0); cycle("wrap1");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 32'd0, 32'd0); cycle("wrap2");
        chk("wrap_cnt", fetch_count, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0); cycle("discard");
        chk("discard_cnt", fetch_count, 32'h0);
        chk("discard_ir", ir, 32'h00000020);

        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, $urandom, 32'(i * 4), $urandom);
            cycle("rinit");
        end
        do_reset("rst_rand");

        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 7);
            sel  = $urandom_range(0, 15);
            a    = 32'($urandom_range(0, 63) * 4);
            if (sel == 0) a = a + 32'($urandom_range(1, 3));
            else if (sel == 1) a = a | (32'd1 << $urandom_range(12, 31));
            case (kind)
                0: drive(1'b0, 1'b1, 1'b0, 1'b1, a, $urandom, $urandom);
                1: drive(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, a, $urandom);
                2: drive(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom, a, $urandom);
                3: drive(1'b0, 1'b1, 1'b0, 1'b0, a, $urandom, $urandom);
                4: drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, a, a, $urandom);
                5: drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, a, a, $urandom);
                6: drive(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'($urandom_range(0, 1)), a, a, $urandom);
                default: drive(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), a, $urandom, $urandom);
            endcase
            cycle("rand");
            if (n % 64 == 63) do_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
